// File: rtl/inv_add_round_key_stage.sv
// -----------------------------------------------------------------------------
// inv_add_round_key_stage
//
// Registered AddRoundKey stage of the iterative AES decryption datapath, placed
// directly upstream of inverse_mix_column. Each accepted beat is XORed with its
// round key and tagged with its round index. The tag also says whether the
// inverse mix-column step applies and whether the beat closes its block.
// A main register plus a skid register let the stage take one more beat while
// downstream stalls, so back-pressure never drops or duplicates a beat.
//
// Parameters:
//   NR  number of cipher rounds (10/12/14); first beat of a block is round NR
//   RW  width of the round index fields (2^RW > NR)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    input beat valid
//   in_ready    stage can accept a beat (registered, = !skid valid)
//   in_first    beat is the first of a block (round NR key)
//   state_in    128-bit state word, byte 0 in [127:120]
//   round_key   128-bit round key, same byte order
//   out_valid   output beat valid
//   out_ready   downstream accepts beat
//   state_out   state_in XOR round_key
//   out_round   round index of the beat (NR down to 0)
//   out_mix_en  route beat through inverse_mix_column (1 <= round <= NR-1)
//   out_last    final beat of block (round 0)
//   busy        block in progress (round counter ACTIVE)
//   err_pulse   one-cycle pulse on a restart or an orphan beat
//   blk_count   [15:0] completed blocks consumed downstream, wraps at 0xFFFF
//               (present only when INV_ARK_BLKCNT_EN is defined)
//
// Optional feature macro: INV_ARK_BLKCNT_EN
// -----------------------------------------------------------------------------
module inv_add_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [127:0]  state_in,
    input  logic [127:0]  round_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  state_out,
    output logic [RW-1:0] out_round,
    output logic          out_mix_en,
    output logic          out_last,
    output logic          busy,
    output logic          err_pulse
`ifdef INV_ARK_BLKCNT_EN
    ,
    output logic [15:0]   blk_count
`endif
);

    localparam logic [RW-1:0] ROUND_NR   = RW'(NR);
    localparam logic [RW-1:0] ROUND_NEXT = RW'(NR - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } ctr_state_e;

    typedef struct packed {
        logic [127:0]  state;
        logic [RW-1:0] round;
        logic          mix_en;
        logic          last;
    } beat_t;

    // Round counter
    ctr_state_e    ctr_q, ctr_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Two-entry buffer
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;

    logic          accept;
    logic          push;
    logic [RW-1:0] new_round;
    beat_t         new_beat;
    logic          main_free;

    assign accept    = in_valid && in_ready;
    // Main register can take a new entry when it is empty or being consumed now.
    assign main_free = !main_valid_q || out_ready;

    // -------------------------------------------------------------------------
    // Round tagging and counter next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        ctr_d     = ctr_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        push      = 1'b0;
        new_round = '0;

        if (accept) begin
            if (in_first) begin
                // Start of a block; arriving while ACTIVE abandons the old one.
                push      = 1'b1;
                new_round = ROUND_NR;
                cnt_d     = ROUND_NEXT;
                ctr_d     = ACTIVE;
                err_d     = (ctr_q == ACTIVE);
            end else if (ctr_q == ACTIVE) begin
                push      = 1'b1;
                new_round = cnt_q;
                if (cnt_q == '0) begin
                    ctr_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else begin
                // Orphan beat: handshake completes but the beat is dropped.
                err_d = 1'b1;
            end
        end

        new_beat.state  = state_in ^ round_key;
        new_beat.round  = new_round;
        new_beat.mix_en = (new_round != '0) && (new_round != ROUND_NR);
        new_beat.last   = (new_round == '0);
    end

    // -------------------------------------------------------------------------
    // Skid buffer next state
    // -------------------------------------------------------------------------
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;

        if (main_free) begin
            if (skid_valid_q) begin
                // in_ready is low whenever skid is full, so no new beat can
                // arrive this cycle; the skid entry simply advances.
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = push;
                if (push) begin
                    main_d = new_beat;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_d       = new_beat;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q        <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
        end else begin
            ctr_q        <= ctr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
        end
    end

    // NOTE: the skid payload is never observed unless skid_valid_q is set, so it
    // carries no reset; only the valid flag has to be cleared.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

`ifdef INV_ARK_BLKCNT_EN
    logic [15:0] blk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else if (main_valid_q && out_ready && main_q.last) begin
            blk_q <= blk_q + 16'd1;
        end
    end

    assign blk_count = blk_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready   = !skid_valid_q;
    assign out_valid  = main_valid_q;
    assign state_out  = main_q.state;
    assign out_round  = main_q.round;
    assign out_mix_en = main_q.mix_en;
    assign out_last   = main_q.last;
    assign busy       = (ctr_q == ACTIVE);
    assign err_pulse  = err_q;

endmodule

// File: doc/inv_add_round_key_stage.md
Name: inv_add_round_key_stage

Overview:
- Registered AddRoundKey stage of the iterative AES decryption datapath. Sits directly upstream of inverse_mix_column.
- XORs the 128-bit state with the supplied round key and tracks the round index per block. Tags each result with whether the inverse mix-column step applies.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so back-pressure never drops a beat.

Parameters:
- NR, 10, number of cipher rounds (10/12/14); sets round-counter start value.
- RW, 4, width of round index fields; must satisfy 2^RW > NR.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_first  input  1  beat is the first of a block (round NR key).
- state_in  input  128  state word, byte 0 in [127:120].
- round_key  input  128  round key, same byte order.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- state_out  output  128  state_in XOR round_key.
- out_round  output  RW  round index of the beat (NR down to 0).
- out_mix_en  output  1  route beat through inverse_mix_column.
- out_last  output  1  final beat of block (round 0).
- busy  output  1  block in progress (counter not idle).
- err_pulse  output  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, in_ready=1, busy=0, err_pulse=0.
  - state_out=0, out_round=0, out_mix_en=0, out_last=0.
  - Both buffer entries invalid; round counter idle.
- Accept: beat is taken when in_valid && in_ready. Output is produced when out_valid && out_ready.
- Latency: an accepted beat appears on the outputs the next cycle when the main register is empty or draining.
- Skid buffer: main register plus skid register.
  - If the main register is held (out_valid && !out_ready) and a beat is accepted, the beat goes to the skid register.
  - in_ready is registered: in_ready = !skid_valid.
  - When the main register drains, the skid entry moves to main in the same cycle.
  - Order is strictly preserved. No beat is ever lost or duplicated.
- Round counter, IDLE/ACTIVE:
  - IDLE + accepted beat with in_first=1: tag round=NR, counter=NR-1, go ACTIVE.
  - ACTIVE + accepted beat with in_first=0: tag round=counter, then decrement. If the tag is 0, out_last=1 and the state returns to IDLE.
  - ACTIVE + accepted beat with in_first=1: restart. Tag round=NR, counter=NR-1, err_pulse=1 for one cycle. The old block is abandoned; its beats already buffered still drain.
  - IDLE + accepted beat with in_first=0: orphan. Beat is discarded (not buffered) and err_pulse=1.
- Tag rules:
  - out_mix_en=1 iff 1 <= out_round <= NR-1.
  - out_last=1 iff out_round==0.
  - Round NR and round 0 beats bypass mix column.
- busy=1 in ACTIVE.
- Simultaneous drain and accept in one cycle is legal in every buffer state. Throughput is 1 beat/cycle with out_ready held high.
- Outputs hold stable while out_valid && !out_ready.
- Reset asserted mid-block clears both buffer entries and returns the counter to IDLE immediately. No partial output follows.

Optional Feature:
- Macro: INV_ARK_BLKCNT_EN.
- With the macro defined:
  - Adds output blk_count [15:0].
  - blk_count increments when a beat with out_last=1 is consumed (out_valid && out_ready), wrapping 0xFFFF->0.
  - blk_count is reset to 0.
- Without the macro: the port and its logic are absent; everything else is identical.

Test Plan:
- Single beat: state_in=69c4e0d86a7b0430d8cdb78070b4c55a, round_key=13111d7fe3944a17f307a78b4d2b30c5, in_first=1 -> next cycle state_out=7ad5fda789ef4e272bca100b3d9ff59f, out_round=10, out_mix_en=0, out_last=0, busy=1.
- Full block NR=10, 11 beats back-to-back, out_ready=1 -> out_round 10,9..0. out_mix_en=0,1x9,0. out_last only on the 11th beat. busy falls after it. Throughput 1/cycle.
- Back-pressure: out_ready=0 for 3 cycles during streaming.
  - in_ready drops after the skid entry fills.
  - Outputs stay stable.
  - After release, all beats emerge in order, none lost.
- Restart: in_first=1 on the 5th beat -> err_pulse one cycle; that beat tagged round 10. The counter then continues 9,8...
- Orphan: in_first=0 beat while IDLE -> err_pulse=1, no out_valid, busy stays 0.
- Async reset mid-block with both entries full -> out_valid=0 and in_ready=1 immediately. With INV_ARK_BLKCNT_EN: 2 full blocks then reset -> blk_count goes 1, 2, then 0.
